// File: rtl/test_sequencer_pkg.sv
// Shared types and constants for the compliance-suite sequencer.
// Holds the FSM state encoding, exit-convention values and a saturating counter helper.
package test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    CHECK   = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } seq_state_e;

  localparam logic [31:0] EXIT_CODE = 32'd93;
  localparam logic [31:0] PASS_GP   = 32'd1;
  localparam logic [31:0] END_WORD  = 32'h0;

  function automatic logic [5:0] sat_inc(input logic [5:0] value, input logic [5:0] limit);
    return (value < limit) ? value + 6'd1 : value;
  endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Image-stream handshake and instruction-memory write port of the sequencer.
// master is the sequencer's view; slave is the image source / insMem side.
interface test_sequencer_if;

  logic        srcValid;
  logic [31:0] srcData;
  logic        srcReady;
  logic        insMemEn;
  logic [31:0] insMemAddr;
  logic [31:0] insMemDataIn;

  modport master (
    input  srcValid, srcData,
    output srcReady, insMemEn, insMemAddr, insMemDataIn
  );

  modport slave (
    output srcValid, srcData,
    input  srcReady, insMemEn, insMemAddr, insMemDataIn
  );

endinterface

// File: rtl/test_sequencer_watchdog.sv
// Per-test run timer: cleared before each run, counts enabled cycles and
// reports expiry on the last allowed cycle, holding there until cleared.
module run_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  assign expired = (count_r == LAST_COUNT);

  // Run-cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && !expired) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Compliance-suite supervisor: loads each program image into insMem, runs the
// core until it signals exit (x17==93) or times out, and records the verdict (x3==1).
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int NUM_TESTS      = 33,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  test_sequencer_if.master        bus,
  output logic                    coreReset,
  output logic                    regClear,
  input  logic [31:0]             dbgA7,
  input  logic [31:0]             dbgGp,
  output logic [5:0]              testIdx,
  output logic                    testDone,
  output logic                    testPass,
  output logic                    testTimeout,
  output logic [5:0]              passCount,
  output logic [5:0]              failCount,
  output logic                    busy,
  output logic                    allDone
);

  seq_state_e        state_r;
  seq_state_e        state_s;
  logic [ADDR_W-1:0] widx_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              wr_en_r;
  logic [5:0]        idx_r;
  logic [5:0]        pass_cnt_r;
  logic [5:0]        fail_cnt_r;
  logic              verdict_pass_r;
  logic              verdict_tmo_r;

  logic hs_s, hs_word_s, hs_end_s, last_word_s, empty_s;
  logic exit_s, expired_s, finish_s, launch_s, last_test_s;

  assign hs_s        = bus.srcValid && (state_r == LOAD);
  assign hs_word_s   = hs_s && (bus.srcData != END_WORD);
  assign hs_end_s    = hs_s && (bus.srcData == END_WORD);
  assign last_word_s = (widx_r == {ADDR_W{1'b1}});
  assign empty_s     = (widx_r == {ADDR_W{1'b0}});
  assign exit_s      = (dbgA7 == EXIT_CODE);
  assign finish_s    = (state_r == RUN) && (exit_s || expired_s);
  assign launch_s    = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_test_s = (idx_r == 6'(NUM_TESTS - 1));

  run_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_r == RELEASE),
    .enable  (state_r == RUN),
    .expired (expired_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = LOAD;
        else       state_s = state_r;
      end
      LOAD: begin
        if (hs_end_s)                      state_s = empty_s ? CHECK : RELEASE;
        else if (hs_word_s && last_word_s) state_s = RELEASE;
        else                               state_s = LOAD;
      end
      RELEASE: state_s = RUN;
      RUN: begin
        if (exit_s || expired_s) state_s = CHECK;
        else                     state_s = RUN;
      end
      CHECK: state_s = NEXT;
      NEXT: begin
        if (last_test_s) state_s = DONE;
        else             state_s = LOAD;
      end
      default: state_s = IDLE;
    endcase
  end

  // insMem write port: one registered write per accepted nonzero word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 32'h0;
      widx_r    <= {ADDR_W{1'b0}};
    end else begin
      wr_en_r <= hs_word_s;
      if (hs_word_s) begin
        wr_addr_r <= widx_r;
        wr_data_r <= bus.srcData;
        widx_r    <= widx_r + ADDR_W'(1);
      end else if (launch_s || (state_r == NEXT)) begin
        widx_r <= {ADDR_W{1'b0}};
      end else begin
        widx_r <= widx_r;
      end
    end
  end

  // Test index, verdict capture and pass/fail tallies
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_r          <= 6'd0;
      pass_cnt_r     <= 6'd0;
      fail_cnt_r     <= 6'd0;
      verdict_pass_r <= 1'b0;
      verdict_tmo_r  <= 1'b0;
    end else if (launch_s) begin
      idx_r      <= 6'd0;
      pass_cnt_r <= 6'd0;
      fail_cnt_r <= 6'd0;
    end else begin
      // Verdict is sampled on the exit cycle, before regClear wipes x3.
      if (finish_s) begin
        verdict_pass_r <= exit_s && (dbgGp == PASS_GP);
        verdict_tmo_r  <= !exit_s;
      end else if (hs_end_s && empty_s) begin
        verdict_pass_r <= 1'b0;
        verdict_tmo_r  <= 1'b0;
      end else begin
        verdict_pass_r <= verdict_pass_r;
        verdict_tmo_r  <= verdict_tmo_r;
      end
      if (state_r == CHECK) begin
        if (verdict_pass_r) pass_cnt_r <= sat_inc(pass_cnt_r, 6'(NUM_TESTS));
        else                fail_cnt_r <= sat_inc(fail_cnt_r, 6'(NUM_TESTS));
      end
      if ((state_r == NEXT) && !last_test_s) idx_r <= idx_r + 6'd1;
    end
  end

  assign bus.srcReady     = (state_r == LOAD);
  assign bus.insMemEn     = wr_en_r;
  assign bus.insMemAddr   = 32'(wr_addr_r);
  assign bus.insMemDataIn = wr_data_r;
  assign coreReset        = (state_r != RUN);
  assign regClear         = (state_r == RELEASE) || (state_r == CHECK);
  assign testDone         = (state_r == CHECK);
  assign testPass         = (state_r == CHECK) && verdict_pass_r;
  assign testTimeout      = (state_r == CHECK) && verdict_tmo_r;
  assign testIdx          = idx_r;
  assign passCount        = pass_cnt_r;
  assign failCount        = fail_cnt_r;
  assign busy             = (state_r != IDLE) && (state_r != DONE);
  assign allDone          = (state_r == DONE);

endmodule
